crypto_bus_master: RTL and testbench
====================================

Name: crypto_bus_master

Overview:
- Bus-side initiator for the cryptographic core's 16-bit data registers.
- Turns queued write/read commands into one-cycle save/send strobes toward a bank of data registers.
- Collects read results, which arrive one cycle after the send strobe, into a return FIFO with a valid/ready handshake.
- Sits between the core sequencer and the data-register bank, driving each register's save_info_bus/send_info_bus pair.

Parameters:
- NUM_REGS, 4, number of data registers addressed; sel width SEL_W = $clog2(NUM_REGS), minimum 1.
- DATA_W, 16, bus word width.
- DEPTH, 4, read-return FIFO depth; power of two, ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous and active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when high together with cmd_valid.
- cmd_write  input  1  1 = write to register, 0 = read from register.
- cmd_sel  input  SEL_W  target register index.
- cmd_wdata  input  DATA_W  write data.
- save_info_bus  output  NUM_REGS  one-hot, one-cycle register write strobe.
- send_info_bus  output  NUM_REGS  one-hot, one-cycle register read strobe.
- save_data_bus  output  DATA_W  write data driven to the registers.
- send_data_bus  input  NUM_REGS*DATA_W  registered read outputs; slice i belongs to register i.
- rd_valid  output  1  read result available.
- rd_ready  input  1  consumer takes the result.
- rd_data  output  DATA_W  FIFO head.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; FIFO emptied (pointers and count 0).
  - Strobes 0; save_data_bus=0; rd_data=0; rd_valid=0; busy=0.
  - A reset mid-transaction aborts it: the read result is discarded and no strobe fires on the following cycle.
- Acceptance: cmd_ready = (state==IDLE) && (fifo_count + 0 < DEPTH). The FIFO must have room even for writes; this keeps ready independent of cmd_write. A handshake occurs at edge T when cmd_valid && cmd_ready.
- FSM states: IDLE, WR, RD_REQ, RD_CAP.
  - IDLE → WR on an accepted write; IDLE → RD_REQ on an accepted read.
  - cmd_sel, cmd_wdata and cmd_write are latched at the handshake edge.
- WR (cycle T+1):
  - save_info_bus[sel]=1 for exactly this cycle; save_data_bus = latched data.
  - Next state IDLE. Back-to-back writes give one strobe every 2 cycles.
- RD_REQ (cycle T+1):
  - send_info_bus[sel]=1 for exactly this cycle; next state RD_CAP.
- RD_CAP (cycle T+2):
  - Sample slice sel of send_data_bus, which was updated by the register at the end of T+1, and push it into the FIFO.
  - Next state IDLE. The result is visible on rd_data with rd_valid=1 in cycle T+3.
- Strobes are never active outside WR/RD_REQ. At most one bit of the two strobe vectors combined is high in any cycle.
- save_data_bus holds its last driven value when idle.
- FIFO behaviour:
  - rd_valid = (count≠0); rd_data = head.
  - Pop on rd_valid && rd_ready.
  - A push and a pop in the same cycle leave count unchanged, including when count==DEPTH−1 or when full with a pop.
  - Pointers wrap modulo DEPTH.
  - A pop when empty is ignored.
  - A push cannot overflow, because acceptance is gated on count<DEPTH and there is at most one outstanding read.
- Out-of-range cmd_sel (≥NUM_REGS):
  - The command is still accepted and walks the FSM, but no strobe bit is set.
  - A write is a no-op.
  - A read pushes an all-zero word.

Optional Feature:
- Macro BUS_SEL_CHECK_EN.
- When defined:
  - Adds output sel_err (1 bit, reset 0).
  - sel_err is set sticky in the cycle after an out-of-range command is accepted.
  - It is cleared only by rst.
- When undefined:
  - No sel_err port.
  - Out-of-range handling as above, silent.

Test Plan:
- Reset then idle 5 cycles → all strobes 0, rd_valid=0, cmd_ready=1, busy=0.
- Write sel=2, data=16'hA5C3 accepted at T → save_info_bus=4'b0100 only in T+1, save_data_bus=16'hA5C3; cmd_ready low in T+1 and high in T+2.
- Read sel=1, model register returns 16'h1234 one cycle after its strobe → send_info_bus=4'b0010 in T+1; rd_valid=1, rd_data=16'h1234 in T+3.
- rd_ready=0, issue 4 reads of regs 0..3 (values 16'h0001..16'h0004) → cmd_ready=0 after the 4th push. Then pop with rd_ready=1 → data 1,2,3,4 in order and cmd_ready returns 1.
- FIFO holds 3 entries; a pop coincides with the RD_CAP push → count stays 3 and order is preserved.
- Read in progress (RD_REQ); assert rst for 1 cycle → no RD_CAP push, rd_valid=0, state IDLE. With BUS_SEL_CHECK_EN and NUM_REGS=3, a read of sel=3 → 16'h0000 returned, sel_err=1 until the next rst.

Source files
------------

// File: rtl/crypto_bus_master.sv
// crypto_bus_master: bus-side initiator for the crypto core's data registers.
// Turns queued write/read commands into one-cycle save/send strobes and
// collects read results into a return FIFO with a valid/ready handshake.
// Optional build macro: BUS_SEL_CHECK_EN adds a sticky sel_err output that
// flags commands addressing a register index >= NUM_REGS.
module crypto_bus_master #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    localparam int SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [SEL_W-1:0]           cmd_sel,
    input  logic [DATA_W-1:0]          cmd_wdata,
    output logic [NUM_REGS-1:0]        save_info_bus,
    output logic [NUM_REGS-1:0]        send_info_bus,
    output logic [DATA_W-1:0]          save_data_bus,
    input  logic [NUM_REGS*DATA_W-1:0] send_data_bus,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
`ifdef BUS_SEL_CHECK_EN
    output logic                       sel_err,
`endif
    output logic                       busy
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WR, RD_REQ, RD_CAP} state_t;

    state_t              state;
    logic [SEL_W-1:0]    sel_q;
    logic [NUM_REGS-1:0] sel_onehot;
    logic [DATA_W-1:0]   cap_word;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      count;
    logic                accept;
    logic                push;
    logic                pop;

    assign cmd_ready = (state == IDLE) && (count < (PTR_W+1)'(DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign push      = (state == RD_CAP);
    assign rd_valid  = (count != '0);
    assign pop       = rd_valid && rd_ready;
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
    assign busy      = (state != IDLE);

    // Decode the incoming select; out-of-range indices decode to all zeros
    always_comb begin
        sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (cmd_sel == SEL_W'(i)) sel_onehot[i] = 1'b1;
        end
    end

    // Pick the addressed register's read slice; out-of-range reads yield zero
    always_comb begin
        cap_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (sel_q == SEL_W'(i)) cap_word = send_data_bus[i*DATA_W +: DATA_W];
        end
    end

    // Command sequencer; strobes are registered so they fire in the cycle after the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sel_q         <= '0;
            save_info_bus <= '0;
            send_info_bus <= '0;
            save_data_bus <= '0;
        end else begin
            save_info_bus <= '0;
            send_info_bus <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sel_q <= cmd_sel;
                        if (cmd_write) begin
                            state         <= WR;
                            save_info_bus <= sel_onehot;
                            save_data_bus <= cmd_wdata;
                        end else begin
                            state         <= RD_REQ;
                            send_info_bus <= sel_onehot;
                        end
                    end
                end
                WR:      state <= IDLE;
                RD_REQ:  state <= RD_CAP;
                RD_CAP:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Return FIFO storage; stale contents after reset are masked by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cap_word;
    end

    // Return FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef BUS_SEL_CHECK_EN
    // Sticky flag for any accepted command addressing a non-existent register
    always_ff @(posedge clk) begin
        if (rst)                              sel_err <= 1'b0;
        else if (accept && sel_onehot == '0)  sel_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_crypto_bus_master.sv
// Testbench for crypto_bus_master: directed vector table, FIFO corner cases,
// out-of-range select on a 3-register instance, and a randomized run against
// a transaction-level queue model.
module tb_crypto_bus_master;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rd_ready = 1'b0;
    logic [1:0]  cmd_sel = '0;
    logic [15:0] cmd_wdata = '0;
    logic        cmd_ready, rd_valid, busy;
    logic [3:0]  save_info_bus, send_info_bus;
    logic [15:0] save_data_bus, rd_data;
    logic [63:0] send_data_bus = '0;

    // second instance with 3 registers so index 3 is out of range
    logic        c3_valid = 1'b0, c3_write = 1'b0, c3_rd_ready = 1'b0;
    logic [1:0]  c3_sel = '0;
    logic [15:0] c3_wdata = '0;
    logic        c3_ready, c3_rd_valid, c3_busy;
    logic [2:0]  c3_save_info, c3_send_info;
    logic [15:0] c3_save_data, c3_rd_data;
    logic [47:0] c3_send_data = '0;

`ifdef BUS_SEL_CHECK_EN
    logic sel_err, c3_sel_err;
`endif

    crypto_bus_master #(.NUM_REGS(NR), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_sel(cmd_sel), .cmd_wdata(cmd_wdata),
        .save_info_bus(save_info_bus), .send_info_bus(send_info_bus),
        .save_data_bus(save_data_bus), .send_data_bus(send_data_bus),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
`ifdef BUS_SEL_CHECK_EN
        .sel_err(sel_err),
`endif
        .busy(busy)
    );

    crypto_bus_master #(.NUM_REGS(3), .DATA_W(DW), .DEPTH(DEPTH)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
        .cmd_write(c3_write), .cmd_sel(c3_sel), .cmd_wdata(c3_wdata),
        .save_info_bus(c3_save_info), .send_info_bus(c3_send_info),
        .save_data_bus(c3_save_data), .send_data_bus(c3_send_data),
        .rd_valid(c3_rd_valid), .rd_ready(c3_rd_ready), .rd_data(c3_rd_data),
`ifdef BUS_SEL_CHECK_EN
        .sel_err(c3_sel_err),
`endif
        .busy(c3_busy)
    );

    // register bank models: read outputs refresh only on their strobe, garbage otherwise
    logic [15:0] bank [NR];
    logic [15:0] bank3 [3];
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (save_info_bus[i]) bank[i] <= save_data_bus;
            send_data_bus[i*16 +: 16] <= send_info_bus[i] ? bank[i] : 16'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
            if (c3_save_info[i]) bank3[i] <= c3_save_data;
            c3_send_data[i*16 +: 16] <= c3_send_info[i] ? bank3[i] : 16'($urandom);
        end
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] mbank [NR];
    logic [15:0] last_wd = '0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drives one command at a negedge; returns at the negedge of cycle T+1
    task automatic send_cmd(input bit wr, input int unsigned sel, input logic [15:0] d);
        cmd_valid = 1'b1; cmd_write = wr; cmd_sel = 2'(sel); cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        if (wr) begin mbank[sel] = d; last_wd = d; end
    endtask

    typedef struct {
        bit          wr;
        int unsigned sel;
        logic [15:0] d;
        logic [3:0]  exp_save;
        logic [3:0]  exp_send;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vt[8];

    // randomized-phase model state
    logic [15:0] q[$];
    bit          act = 1'b0, op_wr = 1'b0, exp_ready, do_pop, do_push;
    int unsigned age = 0, op_sel = 0;
    logic [15:0] op_val = '0;
    logic [3:0]  oh;

    initial begin
        vt[0] = '{1, 2, 16'hA5C3, 4'b0100, 4'b0000, 16'h0000};
        vt[1] = '{1, 1, 16'h1234, 4'b0010, 4'b0000, 16'h0000};
        vt[2] = '{1, 0, 16'hBEEF, 4'b0001, 4'b0000, 16'h0000};
        vt[3] = '{1, 3, 16'h0F0F, 4'b1000, 4'b0000, 16'h0000};
        vt[4] = '{0, 1, 16'h0000, 4'b0000, 4'b0010, 16'h1234};
        vt[5] = '{0, 2, 16'h0000, 4'b0000, 4'b0100, 16'hA5C3};
        vt[6] = '{0, 0, 16'h0000, 4'b0000, 4'b0001, 16'hBEEF};
        vt[7] = '{0, 3, 16'h0000, 4'b0000, 4'b1000, 16'h0F0F};

        // reset then idle
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("rst_save_info", save_info_bus, 4'b0);
        chk("rst_send_info", send_info_bus, 4'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_save_data", save_data_bus, 16'h0);
        chk("rst_rd_data", rd_data, 16'h0);
`ifdef BUS_SEL_CHECK_EN
        chk("rst_sel_err", c3_sel_err, 1'b0);
`endif

        // vector table: writes then readbacks
        for (int i = 0; i < 8; i++) begin
            chk("vec_ready_pre", cmd_ready, 1'b1);
            send_cmd(vt[i].wr, vt[i].sel, vt[i].d);
            chk("vec_save_info", save_info_bus, vt[i].exp_save);
            chk("vec_send_info", send_info_bus, vt[i].exp_send);
            chk("vec_ready_t1", cmd_ready, 1'b0);
            chk("vec_busy_t1", busy, 1'b1);
            if (vt[i].wr) chk("vec_save_data", save_data_bus, vt[i].d);
            tick();
            chk("vec_strobe_off", {save_info_bus, send_info_bus}, 8'h0);
            if (vt[i].wr) begin
                chk("vec_wr_ready_t2", cmd_ready, 1'b1);
                chk("vec_save_hold", save_data_bus, vt[i].d);
            end else begin
                chk("vec_rd_valid_t2", rd_valid, 1'b0);
                tick();
                chk("vec_rd_valid_t3", rd_valid, 1'b1);
                chk("vec_rd_data", rd_data, vt[i].exp_rd);
                rd_ready = 1'b1;
                tick();
                rd_ready = 1'b0;
                chk("vec_rd_popped", rd_valid, 1'b0);
            end
        end

        // FIFO fill to DEPTH with rd_ready low, then drain in order
        for (int i = 0; i < 4; i++) begin
            send_cmd(1'b1, i, 16'(i + 1));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            send_cmd(1'b0, i, 16'h0);
            tick(); tick();
            if (i == 2) chk("fill_ready_at3", cmd_ready, 1'b1);
        end
        chk("full_ready", cmd_ready, 1'b0);
        tick();
        chk("full_ready_hold", cmd_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", rd_valid, 1'b1);
            chk("drain_data", rd_data, 16'(i + 1));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            if (i == 0) chk("drain_ready_back", cmd_ready, 1'b1);
        end
        chk("drain_empty", rd_valid, 1'b0);

        // three entries held, pop coinciding with the RD_CAP push
        for (int i = 0; i < 3; i++) begin
            send_cmd(1'b0, i, 16'h0);
            tick(); tick();
        end
        send_cmd(1'b0, 3, 16'h0);
        tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("pp_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("pp_valid", rd_valid, 1'b1);
            chk("pp_data", rd_data, 16'(i + 2));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        chk("pp_empty", rd_valid, 1'b0);

        // out-of-range select on the 3-register instance
        c3_valid = 1'b1; c3_write = 1'b1; c3_sel = 2'd2; c3_wdata = 16'h2222;
        tick();
        c3_valid = 1'b0;
        chk("c3_wr2_save", c3_save_info, 3'b100);
        tick();
        c3_valid = 1'b1; c3_write = 1'b1; c3_sel = 2'd3; c3_wdata = 16'h5555;
        tick();
        c3_valid = 1'b0;
        chk("c3_oob_wr_save", c3_save_info, 3'b000);
        chk("c3_oob_wr_busy", c3_busy, 1'b1);
`ifdef BUS_SEL_CHECK_EN
        chk("c3_sel_err_set", c3_sel_err, 1'b1);
`endif
        tick();
        c3_valid = 1'b1; c3_write = 1'b0; c3_sel = 2'd3;
        tick();
        c3_valid = 1'b0;
        chk("c3_oob_rd_send", c3_send_info, 3'b000);
        tick(); tick();
        chk("c3_oob_rd_valid", c3_rd_valid, 1'b1);
        chk("c3_oob_rd_data", c3_rd_data, 16'h0);
        c3_rd_ready = 1'b1;
        tick();
        c3_rd_ready = 1'b0;
        c3_valid = 1'b1; c3_write = 1'b0; c3_sel = 2'd2;
        tick();
        c3_valid = 1'b0;
        chk("c3_rd2_send", c3_send_info, 3'b100);
        tick(); tick();
        chk("c3_rd2_data", c3_rd_data, 16'h2222);
        c3_rd_ready = 1'b1;
        tick();
        c3_rd_ready = 1'b0;
`ifdef BUS_SEL_CHECK_EN
        chk("c3_sel_err_sticky", c3_sel_err, 1'b1);
        chk("main_sel_err_clear", sel_err, 1'b0);
`endif

        // reset during RD_REQ aborts the read
        send_cmd(1'b0, 1, 16'h0);
        chk("abort_send_info", send_info_bus, 4'b0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_strobes", {save_info_bus, send_info_bus}, 8'h0);
        chk("abort_ready", cmd_ready, 1'b1);
        tick();
        chk("abort_no_push", rd_valid, 1'b0);
`ifdef BUS_SEL_CHECK_EN
        chk("abort_sel_err_clr", c3_sel_err, 1'b0);
`endif
        last_wd = 16'h0;

        // randomized traffic against a queue-based transaction model
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_ready = !act && (q.size() < DEPTH);
            oh = 4'b0001 << op_sel;
            chk("rnd_ready", cmd_ready, exp_ready);
            chk("rnd_busy", busy, act);
            chk("rnd_rd_valid", rd_valid, q.size() != 0);
            if (q.size() != 0) chk("rnd_rd_data", rd_data, q[0]);
            chk("rnd_save_info", save_info_bus, (act && age == 1 && op_wr) ? oh : 4'b0);
            chk("rnd_send_info", send_info_bus, (act && age == 1 && !op_wr) ? oh : 4'b0);
            chk("rnd_save_data", save_data_bus, last_wd);

            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_write = $urandom_range(0, 2) == 0;
            cmd_sel   = 2'($urandom_range(0, 3));
            cmd_wdata = 16'($urandom);
            rd_ready  = $urandom_range(0, 2) == 0;

            @(posedge clk);
            do_pop  = (q.size() != 0) && rd_ready;
            do_push = act && !op_wr && age == 2;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(op_val);
            if (act) begin
                if ((op_wr && age == 1) || (!op_wr && age == 2)) act = 1'b0;
                else age++;
            end else if (cmd_valid && exp_ready) begin
                act = 1'b1; age = 1; op_wr = cmd_write; op_sel = cmd_sel;
                if (cmd_write) begin
                    mbank[cmd_sel] = cmd_wdata;
                    last_wd = cmd_wdata;
                end else begin
                    op_val = mbank[cmd_sel];
                end
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rd_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
